// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state type and width helper for the ADC capture front end
package adc_capture_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} cap_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/adc_capture_if.sv
// adc_capture_if: valid/ready sample stream out of the capture FIFO
interface adc_capture_if #(parameter int DATA_W = 10);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/adc_capture_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, pointers carry an extra wrap bit
module sync_fifo import adc_capture_pkg::*; #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            din_i,
  output logic [W-1:0]            head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   level_o
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         wr, rd;
  assign level_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  // a pop frees the slot the same-cycle push lands in
  assign wr      = push_i && (!full_o || pop_i);
  assign rd      = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr) wr_q <= wr_q + 1'b1;
      if (rd) rd_q <= rd_q + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/adc_capture.sv
// adc_capture: ADC clock divider, pipeline-latency discard and FIFO capture stream.
// ADC_CAPTURE_TESTPAT_EN adds test_mode, which pushes an internal ramp instead of adc_data.
module adc_capture import adc_capture_pkg::*; #(
  parameter int DATA_W     = 10,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
`ifdef ADC_CAPTURE_TESTPAT_EN
  input  logic                       test_mode,
`endif
  output logic                       adc_clk,
  input  logic [DATA_W-1:0]          adc_data,
  adc_capture_if.master              m,
  output logic [clog2(FIFO_DEPTH):0] level,
  output logic                       overflow,
  input  logic                       clr_ovf
);
  localparam int DCW = clog2(CLK_DIV);
  localparam int DSW = clog2(PIPE_LAT + 2);
  cap_state_t       state_q, state_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [DSW-1:0]   disc_q, disc_d;
  logic             adc_clk_q, adc_clk_d, ovf_q, ovf_d;
  logic             strobe, push, pop, full, empty, fill_done;
  logic [DATA_W-1:0] din, head;
`ifdef ADC_CAPTURE_TESTPAT_EN
  logic [DATA_W-1:0] pat_q, pat_d;
  assign din = test_mode ? pat_q : adc_data;
`else
  assign din = adc_data;
`endif
  always_comb begin
    strobe    = state_q != IDLE && div_cnt_q == DCW'(CLK_DIV - 1);
    push      = strobe && state_q == RUN;
    fill_done = PIPE_LAT == 0 || (strobe && int'(disc_q) == PIPE_LAT - 1);
    state_d   = !en ? IDLE : state_q == IDLE ? FILL : (state_q == FILL && fill_done) ? RUN : state_q;
    div_cnt_d = (!en || state_q == IDLE || div_cnt_q == DCW'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    adc_clk_d = en && int'(div_cnt_d) < CLK_DIV / 2;
    disc_d    = state_q == IDLE ? '0 : (state_q == FILL && strobe) ? disc_q + 1'b1 : disc_q;
    // a drop this cycle wins over a same-cycle clear
    ovf_d     = (push && full && !pop) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
`ifdef ADC_CAPTURE_TESTPAT_EN
    pat_d     = (state_q == IDLE && en) ? '0 : (push && test_mode) ? pat_q + 1'b1 : pat_q;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      disc_q    <= '0;
      adc_clk_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef ADC_CAPTURE_TESTPAT_EN
      pat_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      disc_q    <= disc_d;
      adc_clk_q <= adc_clk_d;
      ovf_q     <= ovf_d;
`ifdef ADC_CAPTURE_TESTPAT_EN
      pat_q     <= pat_d;
`endif
    end
  assign pop       = m.m_valid && m.m_ready;
  assign m.m_valid = !empty;
  assign m.m_data  = head;
  assign adc_clk   = adc_clk_q;
  assign overflow  = ovf_q;
  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed checks of divider timing, discard, FIFO stream, overflow and reset
module tb_adc_capture;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, clr_ovf = 1'b0;
  logic       adc_clk, overflow;
  logic [9:0] adc_data = '0;
  logic [4:0] level;
`ifdef ADC_CAPTURE_TESTPAT_EN
  logic       test_mode = 1'b0;
`endif
  int n_chk = 0, n_pass = 0, ed = 0, dbase = 0;
  adc_capture_if #(.DATA_W(10)) mif();
  adc_capture #(.DATA_W(10), .CLK_DIV(2), .PIPE_LAT(3), .FIFO_DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
`ifdef ADC_CAPTURE_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .adc_clk  (adc_clk),
    .adc_data (adc_data),
    .m        (mif),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  // adc_data for the upcoming edge e is dbase + e/2 - 1, so strobe k carries dbase + k - 1
  task automatic tick();
    @(posedge clk);
    ed++;
    @(negedge clk);
    adc_data = 10'(dbase + ed / 2 - 1);
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic start(input int base);
    en = 1'b1;
    ed = 0;
    dbase = base;
    adc_data = 10'(base - 1);
  endtask
  initial begin
    mif.m_ready = 1'b0;
    ticks(3);
    chk("rst_adc_clk", adc_clk, 0);
    chk("rst_valid", mif.m_valid, 0);
    chk("rst_data", mif.m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    ticks(20);
    chk("idle_adc_clk", adc_clk, 0);
    chk("idle_valid", mif.m_valid, 0);
    chk("idle_level", level, 0);
    // streaming with consumer always ready
    mif.m_ready = 1'b1;
    start(0);
    tick();
    chk("adc_clk_e1", adc_clk, 1);
    tick();
    chk("adc_clk_e2", adc_clk, 0);
    ticks(6);
    chk("no_valid_e8", mif.m_valid, 0);
    tick();
    chk("first_level", level, 1);
    for (int k = 0; k < 6; k++) begin
      chk("stream_valid", mif.m_valid, 1);
      chk("stream_data", mif.m_data, 3 + k);
      tick();
      chk("stream_gap", mif.m_valid, 0);
      chk("stream_level", level, 0);
      tick();
    end
    // overflow: word 9 queued, stall consumer
    mif.m_ready = 1'b0;
    ticks(37);
    chk("sat_level", level, 16);
    chk("sat_ovf", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    tick();
    en = 1'b0;
    tick();
    chk("off_adc_clk", adc_clk, 0);
    mif.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("readback", mif.m_data, 9 + i);
      tick();
    end
    chk("drained_valid", mif.m_valid, 0);
    chk("drained_level", level, 0);
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    // full FIFO, push and pop on the same strobe
    mif.m_ready = 1'b0;
    start(100);
    ticks(39);
    chk("full_level", level, 16);
    chk("full_ovf", overflow, 0);
    chk("refill_discard", mif.m_data, 103);
    tick();
    mif.m_ready = 1'b1;
    tick();
    mif.m_ready = 1'b0;
    chk("pushpop_level", level, 16);
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_head", mif.m_data, 104);
    en = 1'b0;
    mif.m_ready = 1'b1;
    for (int t = 0; t < 40 && mif.m_valid; t++) tick();
    chk("flush_valid", mif.m_valid, 0);
    chk("flush_level", level, 0);
    // drop en with 5 words queued
    mif.m_ready = 1'b0;
    start(200);
    ticks(17);
    chk("five_level", level, 5);
    en = 1'b0;
    tick();
    chk("drop_adc_clk", adc_clk, 0);
    tick();
    chk("drop_adc_clk2", adc_clk, 0);
    chk("drop_level", level, 5);
    mif.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drop_drain", mif.m_data, 203 + i);
      tick();
    end
    chk("drop_empty", mif.m_valid, 0);
    // asynchronous reset mid-run
    mif.m_ready = 1'b0;
    start(0);
    ticks(9);
    chk("pre_rst_adc_clk", adc_clk, 1);
    chk("pre_rst_level", level, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_adc_clk", adc_clk, 0);
    chk("arst_level", level, 0);
    chk("arst_valid", mif.m_valid, 0);
    chk("arst_data", mif.m_data, 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`ifdef ADC_CAPTURE_TESTPAT_EN
    test_mode = 1'b1;
    mif.m_ready = 1'b1;
    start(0);
    for (int i = 0; i < 1030; i++) begin
      for (int t = 0; t < 20 && !mif.m_valid; t++) tick();
      chk("pattern", mif.m_data, i % 1024);
      tick();
    end
    en = 1'b0;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
